// File: rtl/axis_write_cmd_pkg.sv
// Shared types and helpers for the AXI write command sequencer.
// Holds the one-hot state encoding, the OKAY response code and the burst sizing rule.
package axis_write_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    FORWARD = 4'b0010,
    ISSUE   = 4'b0100,
    DRAIN   = 4'b1000
  } state_t;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  // Beats in the next burst: whatever remains, capped at the maximum burst size.
  function automatic logic [31:0] burst_beats(input logic [31:0] remaining,
                                              input logic [31:0] burst_max);
    return (remaining < burst_max) ? remaining : burst_max;
  endfunction

endpackage

// File: rtl/axis_outstanding_cnt.sv
// Up/down count of AXI write bursts issued but not yet responded.
// Increments saturate at 2^(WIDTH-1); decrements at zero are ignored.
module axis_outstanding_cnt #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_empty,
  output logic o_empty_next,
  output logic o_full_next
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_inc;
  logic             w_dec;

  assign w_inc = i_inc && (r_count != MAX);
  assign w_dec = i_dec && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_inc && !w_dec) begin
      w_count_next = r_count + WIDTH'(1);
    end else if (w_dec && !w_inc) begin
      w_count_next = r_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_empty      = (r_count == '0);
  assign o_empty_next = (w_count_next == '0);
  assign o_full_next  = (w_count_next == MAX);

endmodule

// File: rtl/axis_write_cmd.sv
// AXI write address/response sequencer: splits a (address, beats) command into
// bursts, forwards the beat count to the data channel and retires responses.
module axis_write_cmd
  import axis_write_cmd_pkg::*;
#(
  parameter int CFG_DWIDTH         = 32,
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int AXI_LEN_WIDTH      = 8,
  parameter int AXI_DATA_WIDTH     = 64,
  parameter int OUTSTANDING_AWIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [CFG_DWIDTH-1:0]     wcfg_length,
  output logic                      wcfg_val,
  input  logic                      wcfg_rdy,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  output logic                      done,
  output logic                      error
);

  localparam int          BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int          BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [31:0] BURST_MAX  = 32'(1) << AXI_LEN_WIDTH;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_next;
  logic [CFG_DWIDTH-1:0]     r_remaining;
  logic [CFG_DWIDTH-1:0]     w_remaining_next;
  logic [CFG_DWIDTH-1:0]     r_length;
  logic [CFG_DWIDTH-1:0]     w_length_next;
  logic [AXI_LEN_WIDTH-1:0]  r_awlen;
  logic [AXI_LEN_WIDTH-1:0]  w_awlen_next;
  logic                      r_awvalid;
  logic                      w_awvalid_next;
  logic                      r_done;
  logic                      w_done_next;
  logic                      r_error;
  logic                      w_error_next;

  logic                      w_accept;
  logic                      w_aw_hs;
  logic                      w_b_hs;
  logic                      w_bready;
  logic [31:0]               w_burst;
  logic [CFG_DWIDTH-1:0]     w_rem_after;
  logic                      w_empty;
  logic                      w_empty_next;
  logic                      w_full_next;

  assign w_bready    = (r_state != IDLE);
  assign w_accept    = cfg_val && (r_state == IDLE);
  assign w_aw_hs     = r_awvalid && axi_awready;
  assign w_b_hs      = axi_bvalid && w_bready && !w_empty;
  assign w_burst     = burst_beats(32'(r_remaining), BURST_MAX);
  assign w_rem_after = r_remaining - CFG_DWIDTH'(w_burst);

  axis_outstanding_cnt #(
    .WIDTH(OUTSTANDING_AWIDTH + 1)
  ) u_outstanding (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_aw_hs),
    .i_dec       (w_b_hs),
    .o_empty     (w_empty),
    .o_empty_next(w_empty_next),
    .o_full_next (w_full_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cfg_length == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = FORWARD;
          end
        end
      end
      FORWARD: begin
        if (wcfg_rdy) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (w_aw_hs && (w_rem_after == '0)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty_next) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // awlen is precomputed for the next burst so the AW channel stays fully registered.
  always_comb begin
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_length_next    = r_length;
    w_awlen_next     = r_awlen;
    w_error_next     = r_error;
    if (w_accept) begin
      w_addr_next      = AXI_ADDR_WIDTH'(cfg_address);
      w_remaining_next = cfg_length;
      w_length_next    = cfg_length;
      w_awlen_next     = AXI_LEN_WIDTH'(burst_beats(32'(cfg_length), BURST_MAX) - 32'd1);
      w_error_next     = 1'b0;
    end
    if (w_aw_hs) begin
      w_addr_next      = r_addr + (AXI_ADDR_WIDTH'(w_burst) << BEAT_SHIFT);
      w_remaining_next = w_rem_after;
      w_awlen_next     = AXI_LEN_WIDTH'(burst_beats(32'(w_rem_after), BURST_MAX) - 32'd1);
    end
    if (w_b_hs && (axi_bresp != BRESP_OKAY)) begin
      w_error_next = 1'b1;
    end
  end

  // While stalled the count can only fall, so awvalid never drops before its handshake.
  assign w_awvalid_next = (w_state_next == ISSUE) && !w_full_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_length    <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_length    <= w_length_next;
      r_awlen     <= w_awlen_next;
      r_awvalid   <= w_awvalid_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
    end
  end

  assign cfg_rdy     = (r_state == IDLE);
  assign wcfg_val    = (r_state == FORWARD);
  assign wcfg_length = r_length;
  assign axi_awaddr  = r_addr;
  assign axi_awlen   = r_awlen;
  assign axi_awvalid = r_awvalid;
  assign axi_bready  = w_bready;
  assign done        = r_done;
  assign error       = r_error;

endmodule
